// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths: FSM states and line/synchroniser reset levels.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic       LINE_IDLE = 1'b1;
    localparam logic [1:0] SYNC_RST  = 2'b11;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 clocks from d to q; no backpressure (free-running).
module uart_sync2 #(
    parameter logic [1:0] RST_VAL = 2'b11
) (
    input  logic clock,
    input  logic reset_l,
    input  logic d,
    output logic q
);

    logic [1:0] sync;

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            sync <= RST_VAL;
        end else begin
            sync <= {sync[0], d};
        end
    end

    assign q = sync[1];

endmodule

// File: rtl/uart_tx_flow.sv
// UART 8N1/8N2 transmitter with host RTS flow control at frame granularity.
// Latency: start bit on txd the cycle after accept; backpressure: in_ready only in IDLE with host ready.
module uart_tx_flow
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_l,
    input  logic [DIV_W-1:0]     div,
    input  logic                 nstop,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    input  logic                 rtsn,
    output logic                 txd,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    uart_state_t          state;
    logic [DIV_W-1:0]     baud_cnt;
    logic [DIV_W-1:0]     div_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 nstop_q;
    logic                 rts_q;
    logic                 accept;
    logic                 bit_done;

    uart_sync2 #(.RST_VAL(SYNC_RST)) u_rts_sync (
        .clock   (clock),
        .reset_l (reset_l),
        .d       (rtsn),
        .q       (rts_q)
    );

    assign in_ready = (state == IDLE) & ~rts_q;
    assign accept   = in_valid & in_ready;
    assign bit_done = (baud_cnt == '0);

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            state    <= IDLE;
            txd      <= LINE_IDLE;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            div_q    <= '0;
            nstop_q  <= 1'b0;
        end else begin
            // Every bit period is div_q+1 clocks: reload on expiry, else count down.
            if (state != IDLE) begin
                baud_cnt <= bit_done ? div_q : baud_cnt - DIV_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= START;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= div;
                        div_q    <= div;
                        nstop_q  <= nstop;
                        shreg    <= in_data;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            state   <= STOP;
                            txd     <= LINE_IDLE;
                            bit_cnt <= '0;
                        end else begin
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_cnt == CNT_W'(nstop_q)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= LINE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Directed bench for uart_tx_flow: table of frames plus hand-written flow-control/reset sequences.
module tb_uart_tx_flow;

    logic        clock = 1'b0;
    logic        reset_l;
    logic [15:0] div;
    logic        nstop;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        rtsn;
    logic        txd;
    logic        busy;

    // pat bit i is the line level of frame bit i: start, data LSB first, stop(s)
    typedef struct {
        logic [7:0]  data;
        logic [15:0] dv;
        logic        ns;
        logic [10:0] pat;
        int          nbits;
    } frame_t;

    frame_t tbl[5];
    int     tests = 0;
    int     fails = 0;

    uart_tx_flow dut (
        .clock    (clock),
        .reset_l  (reset_l),
        .div      (div),
        .nstop    (nstop),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rtsn     (rtsn),
        .txd      (txd),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns at the negedge just after the accepting posedge.
    task automatic wait_accept(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk(in_ready === 1'b1, name, int'(in_ready), 1);
        @(negedge clock);
    endtask

    // Called at the first negedge after accept; ends on the first IDLE cycle.
    task automatic check_body(input logic [10:0] pat, input int nbits, input int dv,
                              input int rts_at, input int div_at, input logic [15:0] div_new,
                              input string name);
        int         cyc = 0;
        bit         ok;
        logic [1:0] got;
        for (int b = 0; b < nbits; b++) begin
            ok  = 1'b1;
            got = {busy, txd};
            for (int c = 0; c <= dv; c++) begin
                if (cyc == rts_at) rtsn = 1'b1;
                if (cyc == div_at) div = div_new;
                if (txd !== pat[b] || busy !== 1'b1) begin
                    ok  = 1'b0;
                    got = {busy, txd};
                end
                @(negedge clock);
                cyc++;
            end
            chk(ok, $sformatf("%s bit%0d busy/txd", name, b), int'(got), int'({1'b1, pat[b]}));
        end
        chk(txd === 1'b1 && busy === 1'b0, {name, " end busy/txd"}, int'({busy, txd}), 1);
    endtask

    initial begin
        bit ok;

        reset_l  = 1'b0;
        rtsn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        div      = 16'd3;
        nstop    = 1'b0;

        tbl[0] = '{8'hA5, 16'd3, 1'b0, 11'h74A, 10};
        tbl[1] = '{8'h00, 16'd1, 1'b1, 11'h600, 11};
        tbl[2] = '{8'hFF, 16'd0, 1'b1, 11'h7FE, 11};
        tbl[3] = '{8'h01, 16'd2, 1'b0, 11'h602, 10};
        tbl[4] = '{8'h80, 16'd4, 1'b1, 11'h700, 11};

        repeat (3) @(negedge clock);
        chk(txd === 1'b1 && busy === 1'b0 && in_ready === 1'b0, "reset rdy/busy/txd",
            int'({in_ready, busy, txd}), 1);
        reset_l = 1'b1;
        @(negedge clock);
        chk(in_ready === 1'b0, "sync fill 1", int'(in_ready), 0);
        @(negedge clock);
        chk(in_ready === 1'b1, "sync fill 2", int'(in_ready), 1);

        // Table of single frames; entry 0 is the A5 8N1 div=3 40-clock frame
        for (int i = 0; i < 5; i++) begin
            div      = tbl[i].dv;
            nstop    = tbl[i].ns;
            in_data  = tbl[i].data;
            in_valid = 1'b1;
            wait_accept($sformatf("t%0d ready", i));
            in_valid = 1'b0;
            check_body(tbl[i].pat, tbl[i].nbits, int'(tbl[i].dv), -1, -1, 16'd0,
                       $sformatf("t%0d", i));
            @(negedge clock);
        end

        // Flow-control hold
        div   = 16'd3;
        nstop = 1'b0;
        rtsn  = 1'b1;
        repeat (2) @(negedge clock);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            if (in_ready !== 1'b0 || txd !== 1'b1) ok = 1'b0;
            @(negedge clock);
        end
        chk(ok, "rts hold rdy", int'(in_ready), 0);
        rtsn = 1'b0;
        @(negedge clock);
        chk(in_ready === 1'b0, "rts release k", int'(in_ready), 0);
        @(negedge clock);
        chk(in_ready === 1'b1, "rts release k+1", int'(in_ready), 1);
        @(negedge clock);
        in_valid = 1'b0;
        check_body(11'h678, 10, 3, -1, -1, 16'd0, "hold");

        // RTS raised mid-frame, in_valid kept high
        div      = 16'd1;
        in_data  = 8'h00;
        in_valid = 1'b1;
        wait_accept("rtsmid ready");
        check_body(11'h600, 10, 1, 6, -1, 16'd0, "rtsmid");
        ok = 1'b1;
        repeat (10) begin
            if (in_ready !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) ok = 1'b0;
            @(negedge clock);
        end
        chk(ok, "rtsmid no accept", int'({in_ready, busy}), 0);
        in_valid = 1'b0;
        rtsn     = 1'b0;
        repeat (3) @(negedge clock);

        // Back-to-back 8N2 at div=0
        div      = 16'd0;
        nstop    = 1'b1;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        wait_accept("b2b ready");
        in_data = 8'h01;
        check_body(11'h7FE, 11, 0, -1, -1, 16'd0, "b2b first");
        chk(in_ready === 1'b1, "b2b gap ready", int'(in_ready), 1);
        @(negedge clock);
        in_valid = 1'b0;
        check_body(11'h602, 11, 0, -1, -1, 16'd0, "b2b second");
        @(negedge clock);

        // Reset during DATA
        div      = 16'd3;
        nstop    = 1'b0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        wait_accept("rst ready");
        in_valid = 1'b0;
        repeat (8) @(negedge clock);
        chk(busy === 1'b1, "rst pre busy", int'(busy), 1);
        reset_l = 1'b0;
        @(negedge clock);
        chk(txd === 1'b1 && busy === 1'b0 && in_ready === 1'b0, "rst abort rdy/busy/txd",
            int'({in_ready, busy, txd}), 1);
        reset_l = 1'b1;
        @(negedge clock);
        chk(in_ready === 1'b0, "rst refill 1", int'(in_ready), 0);
        @(negedge clock);
        chk(in_ready === 1'b1, "rst refill 2", int'(in_ready), 1);
        ok = 1'b1;
        repeat (10) begin
            if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
            @(negedge clock);
        end
        chk(ok, "rst no resume busy/txd", int'({busy, txd}), 1);

        // Divisor change in flight
        div      = 16'd2;
        in_data  = 8'h55;
        in_valid = 1'b1;
        wait_accept("div ready");
        in_valid = 1'b0;
        check_body(11'h6AA, 10, 2, -1, 10, 16'd9, "div2");
        in_valid = 1'b1;
        wait_accept("div9 ready");
        in_valid = 1'b0;
        check_body(11'h6AA, 10, 9, -1, -1, 16'd0, "div9");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
